// File: rtl/data_mem_ctrl_if.sv
// Core <-> data-memory request/response bundle.
// The master modport is the core's memory stage and the slave modport is the controller.
interface data_mem_ctrl_if;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;            // core consumes the response
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;            // request accepted
    } mem_out_s;

    mem_in_s     to_mem_i;
    logic [31:0] addr_i;
    mem_out_s    from_mem_o;

    modport master (output to_mem_i, output addr_i, input from_mem_o);
    modport slave  (input to_mem_i, input addr_i, output from_mem_o);

endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory bank and single-outstanding request/response controller.
// A request is accepted in IDLE. The response appears latency_p cycles after the accept edge
// and is held until the core consumes it.
module data_mem_ctrl #(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_ctrl_if.slave       bus,
    output logic                 busy_o
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] resp_q, resp_d;

    logic [31:0] bank [2**addr_width_p];

    logic [addr_width_p-1:0] word_idx;
    logic [1:0]              lane;
    logic [31:0]             bank_rdata;
    logic [7:0]              lane_rdata;
    logic                    accept;
    logic                    unused_addr;

    // Upper address bits are ignored, so addresses alias modulo the bank size.
    assign word_idx    = bus.addr_i[addr_width_p+1:2];
    assign lane        = bus.addr_i[1:0];
    assign unused_addr = ^bus.addr_i[31:addr_width_p+2];
    assign bank_rdata  = bank[word_idx];
    assign lane_rdata  = bank_rdata[{lane, 3'b000} +: 8];

    // Gated by reset so nothing is committed on an edge that resets the controller.
    assign accept = (state_q == StIdle) && bus.to_mem_i.valid && reset;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (latency_p > 1) ? StWait : StResp;
                end
            end
            StWait: begin
                if (cnt_d == 4'd0) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.to_mem_i.yumi) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs, derived from registered state except the same-cycle accept.
    always_comb begin
        bus.from_mem_o           = '0;
        bus.from_mem_o.yumi      = accept;
        bus.from_mem_o.valid     = (state_q == StResp);
        bus.from_mem_o.read_data = resp_q;
        busy_o                   = (state_q != StIdle);
    end

    // Latency counter: loaded on accept, WAIT ends when the count reaches zero.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = 4'(latency_p - 1);
        end else if (state_q == StWait && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Response data captured on the accept edge; stores answer with zero.
    always_comb begin
        resp_d = resp_q;
        if (accept) begin
            if (bus.to_mem_i.wen) begin
                resp_d = 32'h0;
            end else if (bus.to_mem_i.byte_not_word) begin
                resp_d = {24'h0, lane_rdata};
            end else begin
                resp_d = bank_rdata;
            end
        end
    end

    // Response register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_q <= 32'h0;
        end else begin
            resp_q <= resp_d;
        end
    end

    // Bank write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && bus.to_mem_i.wen) begin
            if (bus.to_mem_i.byte_not_word) begin
                bank[word_idx][{lane, 3'b000} +: 8] <= bus.to_mem_i.write_data[7:0];
            end else begin
                bank[word_idx] <= bus.to_mem_i.write_data;
            end
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory bank and request/response controller sitting directly downstream of the pipelined core's memory stage.
- Consumes the core's mem_in_s request (valid/wen/byte_not_word/write_data plus data_mem_addr) and produces the mem_out_s response (yumi/valid/read_data).
- Implements the two-phase handshake: request accepted via yumi, response returned after a fixed latency and held until the core's yumi.
- One outstanding request at a time; word and byte access.

Parameters:
- addr_width_p, 10: word-address width; bank holds 2**addr_width_p 32-bit words.
- latency_p, 2: cycles from request accept edge to response valid (legal 1..15).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- to_mem_i  input  mem_in_s  core request: write_data[31:0], valid, wen, byte_not_word, yumi (core consumes response).
- addr_i  input  32  byte address of request (data_mem_addr).
- from_mem_o  output  mem_out_s  response: read_data[31:0], valid, yumi (request accepted).
- busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Address decode:
  - word index = addr_i[addr_width_p+1:2].
  - lane = addr_i[1:0]; lane 0 = bits [7:0].
  - Upper address bits are ignored, so addresses alias modulo bank size.
- FSM states: IDLE, WAIT, RESP. Reset (reset==0 at posedge) forces IDLE, latency counter 0, read_data register 0.
  - Output reset values: from_mem_o.valid=0, from_mem_o.yumi=0, from_mem_o.read_data=0, busy_o=0.
  - Bank contents are NOT cleared by reset.
- Accept:
  - from_mem_o.yumi = (state==IDLE) & to_mem_i.valid, combinational, so it is visible in the same cycle.
  - On the accept edge:
    - Store word: bank[word] <= write_data.
    - Store byte: only lane byte <= write_data[7:0]; other bytes unchanged.
    - Load word: response register <= bank[word].
    - Load byte: response register <= {24'b0, selected lane byte} (zero-extend).
    - Store: response register <= 32'b0.
  - Counter loads latency_p-1.
  - Next state: WAIT if latency_p>1, else RESP.
- WAIT: counter decrements each cycle; at counter==0 the next state is RESP. Requests are ignored (yumi=0) even if valid is held.
- RESP:
  - from_mem_o.valid=1 and read_data = response register, both stable until consumed.
  - When to_mem_i.yumi=1, next state is IDLE.
  - A new request cannot be accepted in the same cycle as the yumi; earliest accept is the following cycle.
- Latency: accept at edge T makes valid high during cycle T+latency_p. Total minimum request-to-next-accept is latency_p+1 cycles.
- Ordering: loads observe all previously accepted stores. A load to the same word immediately after a store returns the stored value.
- read_data is held at its last value outside RESP, but is only meaningful while valid=1.
- to_mem_i.yumi outside RESP has no effect.
- to_mem_i fields other than valid are sampled only on the accept edge; changes after accept do not affect the in-flight operation.
- Reset asserted mid-operation (WAIT or RESP): return to IDLE and drop the pending response. A store already accepted remains committed.
- busy_o = (state != IDLE), registered-state derived.

Test Plan:
- Reset then idle, valid=0 → valid=0, yumi=0, read_data=0, busy_o=0.
- Store word 0xDEADBEEF at addr 0x10, latency_p=2 → yumi high in accept cycle, valid high 2 cycles later with read_data=0. Core yumi → IDLE. Load word 0x10 → read_data=0xDEADBEEF.
- Store byte 0xA5 at addr 0x12 over word 0x11223344 → subsequent word load 0x10 returns 0x11A53344. Byte load 0x12 returns 0x000000A5.
- Response held: core withholds yumi 5 cycles → valid and read_data stable all 5 cycles. A second valid request during that time gets yumi=0. Accept occurs only the cycle after the core's yumi.
- Aliasing with addr_width_p=10: store 0x1 at addr 0x0, load addr 0x1000 → read_data=0x00000001.
- Reset during WAIT after a store of 0x55 to 0x20 → valid never rises, busy_o=0 next cycle. Later load 0x20 returns 0x00000055.
